multicycle_control: RTL and testbench

- Multi-cycle, FSM-driven control unit for the CPE CPU (RV32I base opcodes).
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Runs req/ack handshakes with instruction and data memory.
- Latches a decoded control word per instruction and holds it stable until retire.
- Traps on illegal opcodes and memory timeouts. Sits between the instruction register/memories and the shared datapath.

---
 rtl/multicycle_control_if.sv | 47 ++++
 rtl/multicycle_control.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Handshake/control bundle between the multicycle control unit and the IR, memories and datapath.
interface multicycle_control_if #(
   parameter int OPCODE_W = 7
);
   logic [OPCODE_W-1:0] opcode_w_i;
   logic                imem_ack_w_i_h;
   logic                dmem_ack_w_i_h;
   logic                stall_w_i_h;

   logic                imem_req_w_o_h;
   logic                ir_load_w_o_h;
   logic                dmem_req_w_o_h;
   logic                dmem_we_w_o_h;
   logic                pc_write_w_o_h;
   logic                retire_w_o_h;
   logic                reg_write_w_o_h;
   logic                mem_rd_w_o_h;
   logic                branch_w_o_h;
   logic                jal_w_o_h;
   logic                cmp_branch_w_o_h;
   logic                mem_to_reg_w_o_h;
   logic                imm_to_reg_w_o_h;
   logic                alu_src_a_w_o;
   logic                alu_src_b_w_o;
   logic                pc_to_reg_w_o;
   logic                illegal_w_o_h;
   logic                bus_err_w_o_h;
   logic [2:0]          state_w_o;

   modport master (
      input  opcode_w_i, imem_ack_w_i_h, dmem_ack_w_i_h, stall_w_i_h,
      output imem_req_w_o_h, ir_load_w_o_h, dmem_req_w_o_h, dmem_we_w_o_h,
             pc_write_w_o_h, retire_w_o_h, reg_write_w_o_h, mem_rd_w_o_h,
             branch_w_o_h, jal_w_o_h, cmp_branch_w_o_h, mem_to_reg_w_o_h,
             imm_to_reg_w_o_h, alu_src_a_w_o, alu_src_b_w_o, pc_to_reg_w_o,
             illegal_w_o_h, bus_err_w_o_h, state_w_o
   );

   modport slave (
      output opcode_w_i, imem_ack_w_i_h, dmem_ack_w_i_h, stall_w_i_h,
      input  imem_req_w_o_h, ir_load_w_o_h, dmem_req_w_o_h, dmem_we_w_o_h,
             pc_write_w_o_h, retire_w_o_h, reg_write_w_o_h, mem_rd_w_o_h,
             branch_w_o_h, jal_w_o_h, cmp_branch_w_o_h, mem_to_reg_w_o_h,
             imm_to_reg_w_o_h, alu_src_a_w_o, alu_src_b_w_o, pc_to_reg_w_o,
             illegal_w_o_h, bus_err_w_o_h, state_w_o
   );
endinterface

// File: rtl/multicycle_control.sv
// RV32I multicycle control FSM; `MULTICYCLE_CTRL_FENCE_NOP_EN makes FENCE/SYSTEM legal NOPs.
// Latency 4 cycles FETCH->FETCH (LOAD 5), +1 per ack wait; stall holds DECODE/EXEC/WB, ack waits trap after TIMEOUT_CYCLES.
module multicycle_control #(
   parameter int TIMEOUT_CYCLES = 200,
   parameter int TIMEOUT_W      = 8,
   parameter int OPCODE_W       = 7
) (
   input  logic                 clk_w_i,
   input  logic                 rst_w_i_l,
   multicycle_control_if.master bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      TRAP   = 3'd6
   } state_t;

   typedef struct packed {
      logic rw;
      logic mwr;
      logic mrd;
      logic br;
      logic m2r;
      logic jal;
      logic i2r;
      logic a;
      logic b;
      logic p2r;
      logic cmp;
   } ctrl_t;

   localparam logic [OPCODE_W-1:0] OP_JAL    = OPCODE_W'(7'b1101111);
   localparam logic [OPCODE_W-1:0] OP_LUI    = OPCODE_W'(7'b0110111);
   localparam logic [OPCODE_W-1:0] OP_AUIPC  = OPCODE_W'(7'b0010111);
   localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
   localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
   localparam logic [OPCODE_W-1:0] OP_JALR   = OPCODE_W'(7'b1100111);
   localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
   localparam logic [OPCODE_W-1:0] OP_IMM    = OPCODE_W'(7'b0010011);
   localparam logic [OPCODE_W-1:0] OP_OP     = OPCODE_W'(7'b0110011);
`ifdef MULTICYCLE_CTRL_FENCE_NOP_EN
   localparam logic [OPCODE_W-1:0] OP_FENCE  = OPCODE_W'(7'b0001111);
   localparam logic [OPCODE_W-1:0] OP_SYSTEM = OPCODE_W'(7'b1110011);
`endif

   // With TIMEOUT_CYCLES==0 the truncated constant is never compared.
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_t               state, state_nxt;
   ctrl_t                ctrl_q, dec_cw, ctrl_vis;
   logic                 dec_legal;
   logic [TIMEOUT_W-1:0] tmo_cnt;
   logic                 tmo_hit;
   logic                 illegal_q, bus_err_q;
   logic                 set_illegal, set_bus_err;

   always_comb begin
      dec_legal = 1'b1;
      dec_cw    = '0;
      case (bus.opcode_w_i)
         OP_JAL:    dec_cw = 11'b1_0_0_1_0_1_0_1_1_1_0;
         OP_LUI:    dec_cw = 11'b1_0_0_0_0_0_1_0_0_0_0;
         OP_AUIPC:  dec_cw = 11'b1_0_0_0_0_0_0_1_1_0_0;
         OP_BRANCH: dec_cw = 11'b0_0_0_1_0_0_0_1_1_0_1;
         OP_STORE:  dec_cw = 11'b0_1_0_0_0_0_0_0_0_0_0;
         OP_JALR:   dec_cw = 11'b1_0_0_1_0_1_0_1_1_1_0;
         OP_LOAD:   dec_cw = 11'b1_0_1_0_1_0_0_0_1_0_0;
         OP_IMM:    dec_cw = 11'b1_0_0_0_0_0_0_0_1_0_0;
         OP_OP:     dec_cw = 11'b1_0_0_0_0_0_0_0_0_0_0;
`ifdef MULTICYCLE_CTRL_FENCE_NOP_EN
         OP_FENCE, OP_SYSTEM: dec_cw = '0;
`endif
         default:   dec_legal = 1'b0;
      endcase
   end

   // An ack in the last allowed cycle still wins over the timeout.
   assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
      if (!rst_w_i_l) begin
         state     <= IDLE;
         ctrl_q    <= '0;
         tmo_cnt   <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == DECODE && state_nxt == EXEC)
            ctrl_q <= dec_cw;
         if (state != state_nxt)
            tmo_cnt <= '0;
         else if (state == FETCH || state == MEM)
            tmo_cnt <= tmo_cnt + 1'b1;
         if (set_illegal)
            illegal_q <= 1'b1;
         if (set_bus_err)
            bus_err_q <= 1'b1;
      end
   end

   always_comb begin
      state_nxt           = state;
      set_illegal         = 1'b0;
      set_bus_err         = 1'b0;
      bus.imem_req_w_o_h  = 1'b0;
      bus.ir_load_w_o_h   = 1'b0;
      bus.dmem_req_w_o_h  = 1'b0;
      bus.dmem_we_w_o_h   = 1'b0;
      bus.pc_write_w_o_h  = 1'b0;
      bus.retire_w_o_h    = 1'b0;
      bus.reg_write_w_o_h = 1'b0;
      case (state)
         IDLE: state_nxt = FETCH;
         FETCH: begin
            bus.imem_req_w_o_h = 1'b1;
            if (bus.imem_ack_w_i_h) begin
               bus.ir_load_w_o_h = 1'b1;
               state_nxt         = DECODE;
            end else if (tmo_hit) begin
               set_bus_err = 1'b1;
               state_nxt   = TRAP;
            end
         end
         DECODE: begin
            if (!bus.stall_w_i_h) begin
               if (dec_legal) begin
                  state_nxt = EXEC;
               end else begin
                  set_illegal = 1'b1;
                  state_nxt   = TRAP;
               end
            end
         end
         EXEC: begin
            if (!bus.stall_w_i_h)
               state_nxt = (ctrl_q.mrd || ctrl_q.mwr) ? MEM : WB;
         end
         MEM: begin
            bus.dmem_req_w_o_h = 1'b1;
            bus.dmem_we_w_o_h  = ctrl_q.mwr;
            if (bus.dmem_ack_w_i_h) begin
               // Stores have nothing to write back, so they retire on the ack.
               if (ctrl_q.mwr) begin
                  bus.pc_write_w_o_h = 1'b1;
                  bus.retire_w_o_h   = 1'b1;
                  state_nxt          = FETCH;
               end else begin
                  state_nxt = WB;
               end
            end else if (tmo_hit) begin
               set_bus_err = 1'b1;
               state_nxt   = TRAP;
            end
         end
         WB: begin
            if (!bus.stall_w_i_h) begin
               bus.reg_write_w_o_h = ctrl_q.rw;
               bus.pc_write_w_o_h  = 1'b1;
               bus.retire_w_o_h    = 1'b1;
               state_nxt           = FETCH;
            end
         end
         TRAP:    state_nxt = TRAP;
         default: state_nxt = TRAP;
      endcase
   end

   assign ctrl_vis = (state == EXEC || state == MEM || state == WB) ? ctrl_q : '0;

   assign bus.mem_rd_w_o_h     = ctrl_vis.mrd;
   assign bus.branch_w_o_h     = ctrl_vis.br;
   assign bus.jal_w_o_h        = ctrl_vis.jal;
   assign bus.cmp_branch_w_o_h = ctrl_vis.cmp;
   assign bus.mem_to_reg_w_o_h = ctrl_vis.m2r;
   assign bus.imm_to_reg_w_o_h = ctrl_vis.i2r;
   assign bus.alu_src_a_w_o    = ctrl_vis.a;
   assign bus.alu_src_b_w_o    = ctrl_vis.b;
   assign bus.pc_to_reg_w_o    = ctrl_vis.p2r;
   assign bus.illegal_w_o_h    = illegal_q;
   assign bus.bus_err_w_o_h    = bus_err_q;
   assign bus.state_w_o        = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with TIMEOUT_CYCLES=5; inputs change on the falling edge.
module tb_multicycle_control;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   multicycle_control_if #(.OPCODE_W(7)) bus ();

   multicycle_control #(
      .TIMEOUT_CYCLES(5),
      .TIMEOUT_W(8),
      .OPCODE_W(7)
   ) dut (
      .clk_w_i(clk),
      .rst_w_i_l(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {state, imem_req, ir_load, dmem_req, dmem_we, pc_write, retire, reg_write, illegal, bus_err}
   logic [11:0] outs;
   assign outs = {bus.state_w_o, bus.imem_req_w_o_h, bus.ir_load_w_o_h, bus.dmem_req_w_o_h,
                  bus.dmem_we_w_o_h, bus.pc_write_w_o_h, bus.retire_w_o_h, bus.reg_write_w_o_h,
                  bus.illegal_w_o_h, bus.bus_err_w_o_h};
   // {mem_rd, branch, jal, cmp_branch, mem_to_reg, imm_to_reg, alu_src_a, alu_src_b, pc_to_reg}
   logic [8:0] cw;
   assign cw = {bus.mem_rd_w_o_h, bus.branch_w_o_h, bus.jal_w_o_h, bus.cmp_branch_w_o_h,
                bus.mem_to_reg_w_o_h, bus.imm_to_reg_w_o_h, bus.alu_src_a_w_o,
                bus.alu_src_b_w_o, bus.pc_to_reg_w_o};

   localparam logic [6:0] JAL = 7'b1101111, LUI = 7'b0110111, BRANCH = 7'b1100011;
   localparam logic [6:0] STORE = 7'b0100011, LOAD = 7'b0000011, OPIMM = 7'b0010011;
   localparam logic [6:0] BADOP = 7'b1111111, FENCE = 7'b0001111;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic co(input string tag, input logic [2:0] st, input logic [8:0] b);
      chk(tag, outs, {st, b});
   endtask

   task automatic cc(input string tag, input logic [8:0] c);
      chk(tag, {3'b000, cw}, {3'b000, c});
   endtask

   task automatic cyc(input logic [6:0] op, input logic ia, input logic da, input logic st);
      @(negedge clk);
      bus.opcode_w_i     = op;
      bus.imem_ack_w_i_h = ia;
      bus.dmem_ack_w_i_h = da;
      bus.stall_w_i_h    = st;
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      bus.imem_ack_w_i_h = 1'b0;
      bus.dmem_ack_w_i_h = 1'b0;
      bus.stall_w_i_h    = 1'b0;
      #1;
      co({tag, "_rst"}, 3'd0, 9'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      co({tag, "_idle"}, 3'd0, 9'b0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.opcode_w_i     = 7'd0;
      bus.imem_ack_w_i_h = 1'b0;
      bus.dmem_ack_w_i_h = 1'b0;
      bus.stall_w_i_h    = 1'b0;
      #3;
      co("reset_outs", 3'd0, 9'b0);
      cc("reset_cw", 9'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      co("idle", 3'd0, 9'b0);

      // OP-IMM, zero-wait fetch: FETCH DECODE EXEC WB
      cyc(OPIMM, 1, 0, 0); co("opimm_fetch", 3'd1, 9'b110000000);
      cyc(OPIMM, 0, 0, 0); co("opimm_dec", 3'd2, 9'b0); cc("opimm_dec_cw", 9'b0);
      cyc(OPIMM, 0, 0, 0); co("opimm_exec", 3'd3, 9'b0); cc("opimm_exec_cw", 9'b000000010);
      cyc(OPIMM, 0, 0, 0); co("opimm_wb", 3'd5, 9'b000011100); cc("opimm_wb_cw", 9'b000000010);

      // LOAD with three data wait cycles
      cyc(LOAD, 1, 0, 0); co("load_fetch", 3'd1, 9'b110000000);
      cyc(LOAD, 0, 0, 0); co("load_dec", 3'd2, 9'b0);
      cyc(LOAD, 0, 0, 0); co("load_exec", 3'd3, 9'b0); cc("load_exec_cw", 9'b100010010);
      for (int i = 0; i < 3; i++) begin
         cyc(LOAD, 0, 0, 0); co("load_mem_wait", 3'd4, 9'b001000000);
      end
      cyc(LOAD, 0, 1, 0); co("load_mem_ack", 3'd4, 9'b001000000);
      cyc(LOAD, 0, 0, 0); co("load_wb", 3'd5, 9'b000011100); cc("load_wb_cw", 9'b100010010);

      // STORE retires on the data ack
      cyc(STORE, 1, 0, 0); co("store_fetch", 3'd1, 9'b110000000);
      cyc(STORE, 0, 0, 0); co("store_dec", 3'd2, 9'b0);
      cyc(STORE, 0, 0, 0); co("store_exec", 3'd3, 9'b0); cc("store_exec_cw", 9'b0);
      cyc(STORE, 0, 1, 0); co("store_mem_ack", 3'd4, 9'b001111000);

      // BRANCH with two stalled WB cycles
      cyc(BRANCH, 1, 0, 0); co("br_fetch", 3'd1, 9'b110000000);
      cyc(BRANCH, 0, 0, 0); co("br_dec", 3'd2, 9'b0);
      cyc(BRANCH, 0, 0, 1); co("br_exec_stall", 3'd3, 9'b0); cc("br_exec_cw", 9'b010100110);
      cyc(BRANCH, 0, 0, 0); co("br_exec", 3'd3, 9'b0);
      cyc(BRANCH, 0, 0, 1); co("br_wb_stall1", 3'd5, 9'b0);
      cyc(BRANCH, 0, 0, 1); co("br_wb_stall2", 3'd5, 9'b0);
      cyc(BRANCH, 0, 0, 0); co("br_wb_go", 3'd5, 9'b000011000); cc("br_wb_cw", 9'b010100110);

      // JAL with a DECODE stall
      cyc(JAL, 1, 0, 0); co("jal_fetch", 3'd1, 9'b110000000);
      cyc(JAL, 0, 0, 1); co("jal_dec_stall", 3'd2, 9'b0);
      cyc(JAL, 0, 0, 0); co("jal_dec", 3'd2, 9'b0);
      cyc(JAL, 0, 0, 0); co("jal_exec", 3'd3, 9'b0); cc("jal_exec_cw", 9'b011000111);
      cyc(JAL, 0, 0, 0); co("jal_wb", 3'd5, 9'b000011100);

      // LUI
      cyc(LUI, 1, 0, 0); co("lui_fetch", 3'd1, 9'b110000000);
      cyc(LUI, 0, 0, 0); co("lui_dec", 3'd2, 9'b0);
      cyc(LUI, 0, 0, 0); co("lui_exec", 3'd3, 9'b0); cc("lui_exec_cw", 9'b000001000);
      cyc(LUI, 0, 0, 0); co("lui_wb", 3'd5, 9'b000011100);

      // Stall is ignored in FETCH and MEM
      cyc(LOAD, 1, 0, 1); co("fetch_stall_ign", 3'd1, 9'b110000000);
      cyc(LOAD, 0, 0, 0); co("fsi_dec", 3'd2, 9'b0);
      cyc(LOAD, 0, 0, 0); co("fsi_exec", 3'd3, 9'b0);
      cyc(LOAD, 0, 1, 1); co("mem_stall_ign", 3'd4, 9'b001000000);
      cyc(LOAD, 0, 0, 0); co("msi_wb", 3'd5, 9'b000011100);

      // Reset while a store is waiting in MEM
      cyc(STORE, 1, 0, 0); co("rst_st_fetch", 3'd1, 9'b110000000);
      cyc(STORE, 0, 0, 0); co("rst_st_dec", 3'd2, 9'b0);
      cyc(STORE, 0, 0, 0); co("rst_st_exec", 3'd3, 9'b0);
      cyc(STORE, 0, 0, 0); co("rst_st_mem", 3'd4, 9'b001100000);
      #2;
      rst_n = 1'b0;
      #1;
      co("midmem_rst_now", 3'd0, 9'b0); cc("midmem_rst_cw", 9'b0);
      cyc(STORE, 0, 0, 0); co("midmem_rst_hold", 3'd0, 9'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      co("midmem_idle", 3'd0, 9'b0);

      // Fetch timeout: five requests, then bus error trap
      for (int i = 0; i < 5; i++) begin
         cyc(OPIMM, 0, 0, 0); co("tmo_fetch_req", 3'd1, 9'b100000000);
      end
      cyc(OPIMM, 0, 0, 0); co("tmo_trap", 3'd6, 9'b000000001);
      cyc(OPIMM, 1, 1, 0); co("tmo_trap_hold", 3'd6, 9'b000000001);

      // Ack in the final allowed cycle wins; then an illegal opcode
      do_reset("ack5");
      for (int i = 0; i < 4; i++) begin
         cyc(BADOP, 0, 0, 0); co("ack5_wait", 3'd1, 9'b100000000);
      end
      cyc(BADOP, 1, 0, 0); co("ack5_fetch", 3'd1, 9'b110000000);
      cyc(BADOP, 0, 0, 0); co("ack5_dec_noerr", 3'd2, 9'b0);
      cyc(BADOP, 0, 0, 0); co("illegal_trap", 3'd6, 9'b000000010);
      cyc(BADOP, 1, 0, 0); co("illegal_hold", 3'd6, 9'b000000010);

      // FENCE: NOP with the option, illegal without it
      do_reset("fence");
      cyc(FENCE, 1, 0, 0); co("fence_fetch", 3'd1, 9'b110000000);
      cyc(FENCE, 0, 0, 0); co("fence_dec", 3'd2, 9'b0);
`ifdef MULTICYCLE_CTRL_FENCE_NOP_EN
      cyc(FENCE, 0, 0, 0); co("fence_exec", 3'd3, 9'b0); cc("fence_cw", 9'b0);
      cyc(FENCE, 0, 0, 0); co("fence_wb", 3'd5, 9'b000011000);
      cyc(FENCE, 0, 0, 0); co("fence_refetch", 3'd1, 9'b100000000);
`else
      cyc(FENCE, 0, 0, 0); co("fence_trap", 3'd6, 9'b000000010);
      cyc(FENCE, 1, 0, 0); co("fence_trap_hold", 3'd6, 9'b000000010);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
